// File: rtl/rvv_rt_xrf_arb.sv
// rvv_rt_xrf_arb
//
// Retire-side scalar writeback arbiter. It takes up to NUM_RT_UOP XRF results
// per cycle from retire and stores them in order in a circular FIFO. It drains
// them to the RVS core one entry per cycle. It also folds the per-lane vxsat
// flags into a single sticky set request.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   rt_xrf_valid_rt2arb [N]    per-lane result valid from retire
//   rt_xrf_rd_rt2arb    [N]    per-lane destination index
//   rt_xrf_data_rt2arb  [N]    per-lane result data
//   rt_xrf_ready_arb2rt [N]    per-lane accept (prefix-shaped)
//   rt_xrf_valid_rvv2rvs       head entry valid toward RVS
//   rt_xrf_rvv2rvs             head entry {rd, data}
//   rt_xrf_ready_rvs2rvv       RVS accept of the head entry
//   vxsat_valid_rt2arb  [N]    per-lane vxsat update valid
//   vxsat_rt2arb        [N]    per-lane saturation flag
//   wr_vxsat_valid/wr_vxsat    pending vxsat set request / value (always 1)
//   wr_vxsat_ready             RVS accept of the vxsat write
//   arb_idle                   FIFO empty and no vxsat pending
module rvv_rt_xrf_arb #(
   parameter int NUM_RT_UOP = 4,
   parameter int DEPTH      = 8,
   parameter int XLEN       = 32,
   parameter int RD_W       = 5
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_RT_UOP-1:0]                rt_xrf_valid_rt2arb,
   input  logic [NUM_RT_UOP-1:0][RD_W-1:0]      rt_xrf_rd_rt2arb,
   input  logic [NUM_RT_UOP-1:0][XLEN-1:0]      rt_xrf_data_rt2arb,
   output logic [NUM_RT_UOP-1:0]                rt_xrf_ready_arb2rt,
   output logic                                 rt_xrf_valid_rvv2rvs,
   output logic [RD_W+XLEN-1:0]                 rt_xrf_rvv2rvs,
   input  logic                                 rt_xrf_ready_rvs2rvv,
   input  logic [NUM_RT_UOP-1:0]                vxsat_valid_rt2arb,
   input  logic [NUM_RT_UOP-1:0]                vxsat_rt2arb,
   output logic                                 wr_vxsat_valid,
   output logic                                 wr_vxsat,
   input  logic                                 wr_vxsat_ready,
   output logic                                 arb_idle
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = RD_W + XLEN;

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;

   logic [CNT_W-1:0] free;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] pushed;
   logic [PTR_W-1:0] slot;
   logic             pop;
   logic             set;

   // Acceptance and push placement. acc is the running count of valid lanes,
   // so lane i lands in slot wptr + acc - 1. Because acc only grows, the
   // refused lanes are always the upper ones. free comes from the registered
   // count, so a pop in this cycle cannot open a slot until the next cycle.
   always_comb begin
      mem_d               = mem_q;
      free                = CNT_W'(DEPTH) - cnt_q;
      acc                 = '0;
      pushed              = '0;
      slot                = '0;
      rt_xrf_ready_arb2rt = '0;
      for (int i = 0; i < NUM_RT_UOP; i++) begin
         acc = acc + CNT_W'(rt_xrf_valid_rt2arb[i]);
         rt_xrf_ready_arb2rt[i] = rst_n & (acc <= free);
         if (rt_xrf_valid_rt2arb[i] && rt_xrf_ready_arb2rt[i]) begin
            slot         = wptr_q + PTR_W'(acc - CNT_W'(1));
            mem_d[slot]  = {rt_xrf_rd_rt2arb[i], rt_xrf_data_rt2arb[i]};
            pushed       = acc;
         end
      end
   end

   always_comb begin
      pop    = (cnt_q != '0) & rt_xrf_ready_rvs2rvv;
      cnt_d  = cnt_q + pushed - CNT_W'(pop);
      wptr_d = wptr_q + PTR_W'(pushed);
      rptr_d = rptr_q + PTR_W'(pop);
      set    = |(vxsat_valid_rt2arb & vxsat_rt2arb);
      // A set that lands in the handshake cycle keeps the request alive.
      pend_d = set | (pend_q & ~wr_vxsat_ready);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         rptr_q <= '0;
         wptr_q <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         pend_q <= pend_d;
      end
   end

   // Storage carries no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rt_xrf_valid_rvv2rvs = (cnt_q != '0);
   assign rt_xrf_rvv2rvs       = mem_q[rptr_q];
   assign wr_vxsat_valid       = pend_q;
   assign wr_vxsat             = pend_q;
   assign arb_idle             = (cnt_q == '0) & ~pend_q;

endmodule

// File: tb/tb_rvv_rt_xrf_arb.sv
module tb_rvv_rt_xrf_arb;
   localparam int N     = 4;
   localparam int DEPTH = 8;
   localparam int XLEN  = 32;
   localparam int RD_W  = 5;
   localparam int EW    = RD_W + XLEN;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [N-1:0]             v_in;
   logic [N-1:0][RD_W-1:0]   rd_in;
   logic [N-1:0][XLEN-1:0]   data_in;
   logic [N-1:0]             rdy_out;
   logic                     vout;
   logic [EW-1:0]            head;
   logic                     rvs_rdy;
   logic [N-1:0]             vxv_in, vxs_in;
   logic                     wvv, wv, wrr, idle;

   int nassert = 0;
   int nfail   = 0;

   // Reference model: ordered list of stored entries plus the sticky flag.
   logic [EW-1:0] mq[$];
   logic          pend;

   always #5 clk = ~clk;

   rvv_rt_xrf_arb #(.NUM_RT_UOP(N), .DEPTH(DEPTH), .XLEN(XLEN), .RD_W(RD_W)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .rt_xrf_valid_rt2arb  (v_in),
      .rt_xrf_rd_rt2arb     (rd_in),
      .rt_xrf_data_rt2arb   (data_in),
      .rt_xrf_ready_arb2rt  (rdy_out),
      .rt_xrf_valid_rvv2rvs (vout),
      .rt_xrf_rvv2rvs       (head),
      .rt_xrf_ready_rvs2rvv (rvs_rdy),
      .vxsat_valid_rt2arb   (vxv_in),
      .vxsat_rt2arb         (vxs_in),
      .wr_vxsat_valid       (wvv),
      .wr_vxsat             (wv),
      .wr_vxsat_ready       (wrr),
      .arb_idle             (idle)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setin(input logic [N-1:0] v, input int base, input logic rr,
                        input logic [N-1:0] vv, input logic [N-1:0] vs, input logic w);
      v_in = v;
      for (int i = 0; i < N; i++) begin
         rd_in[i]   = RD_W'(base + i);
         data_in[i] = XLEN'(32'hA0 + base + i);
      end
      rvs_rdy = rr;
      vxv_in  = vv;
      vxs_in  = vs;
      wrr     = w;
   endtask

   // One clock: check outputs against the model, clock, then advance the model.
   task automatic step();
      int            free, nv;
      logic [N-1:0]  er;
      logic [EW-1:0] acc_q[$];
      logic          popv;
      #3;
      free = DEPTH - mq.size();
      nv   = 0;
      for (int i = 0; i < N; i++) begin
         nv    += int'(v_in[i]);
         er[i]  = rst_n && (nv <= free);
         if (v_in[i] && er[i]) acc_q.push_back({rd_in[i], data_in[i]});
      end
      popv = (mq.size() != 0) && rvs_rdy;
      chk("ready", 64'(rdy_out), 64'(er));
      chk("valid", 64'(vout), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("head", 64'(head), 64'(mq[0]));
      chk("wr_vxsat_valid", 64'(wvv), 64'(pend));
      chk("wr_vxsat", 64'(wv), 64'(pend));
      chk("idle", 64'(idle), 64'((mq.size() == 0) && !pend));
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         pend = 1'b0;
      end else begin
         if (popv) void'(mq.pop_front());
         foreach (acc_q[k]) mq.push_back(acc_q[k]);
         pend = (|(vxv_in & vxs_in)) | (pend & ~wrr);
      end
      #1;
   endtask

   task automatic drain();
      int guard = 0;
      setin('0, 0, 1'b1, '0, '0, 1'b1);
      while ((mq.size() != 0 || pend) && guard < 30) begin
         step();
         guard++;
      end
      if (guard >= 30) chk("drain_timeout", 64'(mq.size()), 64'd0);
      step();
   endtask

   initial begin
      pend  = 1'b0;
      rst_n = 1'b0;
      setin('0, 0, 1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      step();  // still in reset: ready forced low, reset outputs
      rst_n = 1'b1;

      // Four lanes into an empty FIFO, RVS always ready
      setin(4'b1111, 1, 1'b1, '0, '0, 1'b0);
      step();
      drain();

      // Backpressure: fill to 8 and then see the full refusal
      setin(4'b1111, 1, 1'b0, '0, '0, 1'b0);
      step();
      setin(4'b1111, 5, 1'b0, '0, '0, 1'b0);
      step();
      setin(4'b1111, 9, 1'b0, '0, '0, 1'b0);
      step();
      step();
      drain();

      // cnt=6 then a sparse lane mask; lane 3 is refused and retried
      setin(4'b1111, 1, 1'b0, '0, '0, 1'b0);
      step();
      setin(4'b0011, 5, 1'b0, '0, '0, 1'b0);
      step();
      setin(4'b1101, 10, 1'b0, '0, '0, 1'b0);
      step();
      setin(4'b1000, 10, 1'b1, '0, '0, 1'b0);
      step();
      step();
      drain();

      // cnt=7 with push and pop together, write pointer wrapping
      setin(4'b1111, 1, 1'b0, '0, '0, 1'b0);
      step();
      setin(4'b0111, 5, 1'b0, '0, '0, 1'b0);
      step();
      setin(4'b0001, 20, 1'b1, '0, '0, 1'b0);
      step();
      setin('0, 0, 1'b0, '0, '0, 1'b0);
      step();
      drain();

      // vxsat held while unacknowledged, re-set in the handshake cycle
      setin('0, 0, 1'b0, 4'b0100, 4'b0100, 1'b0);
      step();
      setin('0, 0, 1'b0, 4'b0010, 4'b0000, 1'b0);
      step();
      step();
      step();
      setin('0, 0, 1'b0, 4'b1000, 4'b1000, 1'b1);
      step();
      setin('0, 0, 1'b0, '0, '0, 1'b1);
      step();
      step();

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         v_in    = N'($urandom);
         for (int i = 0; i < N; i++) begin
            rd_in[i]   = RD_W'($urandom);
            data_in[i] = $urandom;
         end
         rvs_rdy = ($urandom_range(0, 3) != 0);
         vxv_in  = N'($urandom);
         vxs_in  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         wrr     = $urandom_range(0, 1) != 0;
         step();
      end
      drain();

      // Reset with five entries buffered and vxsat pending
      setin(4'b1111, 1, 1'b0, 4'b0001, 4'b0001, 1'b0);
      step();
      setin(4'b0001, 5, 1'b0, '0, '0, 1'b0);
      step();
      rst_n = 1'b0;
      setin('0, 0, 1'b0, '0, '0, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_valid", 64'(vout), 64'd0);
      chk("post_reset_idle", 64'(idle), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end
endmodule
